// File: rtl/instr_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_prefetch_unit
// Description : Fetch-stage front end. Issues sequential word fetches to a
//               variable-latency instruction memory (one request outstanding
//               at a time). Returned words are buffered with their PCs in a
//               small FIFO that feeds the IF/ID register. Redirects flush the
//               buffer and squash any in-flight fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                         CLK,
  input  logic                         RESET,
  output logic                         imem_req,
  output logic [31:0]                  imem_addr,
  input  logic                         imem_ready,
  input  logic                         imem_rvalid,
  input  logic [31:0]                  imem_rdata,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  input  logic                         stall,
  output logic                         instr_valid,
  output logic [31:0]                  instr,
  output logic [31:0]                  instr_pc,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned CW        = $clog2(DEPTH + 1);
  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] C_NOP     = 32'h0000_0013;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [AW-1:0] C_PTR1  = AW'(1);

  // IDLE : no credit, nothing outstanding
  // REQ  : request presented, waiting for acceptance
  // WAIT : request accepted, waiting for its response
  // DROP : accepted request was squashed by a redirect; discard its response
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]     pc_mem_q   [DEPTH];
  logic [31:0]     pc_mem_d   [DEPTH];
  logic [31:0]     data_mem_q [DEPTH];
  logic [31:0]     data_mem_d [DEPTH];

  logic            accept;
  logic            push;
  logic            pop;
  logic [CW-1:0]   count_after_push;

  // Handshake qualifiers shared by the FSM and the FIFO
  assign accept           = (state_q == ST_REQ) && imem_ready;
  assign pop              = instr_valid && !stall;
  // Occupancy if the response arriving now is pushed (used for the WAIT credit check)
  assign count_after_push = count_q + C_ONE - (pop ? C_ONE : '0);

  // Fetch FSM next-state, fetch PC update and push decision; redirect overrides everything
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (count_q < C_DEPTH) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (accept) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = (count_after_push < C_DEPTH) ? ST_REQ : ST_IDLE;
        end
      end
      ST_DROP: begin
        if (imem_rvalid) begin
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (redirect_valid) begin
      push       = 1'b0;
      fetch_pc_d = redirect_pc & ~32'h0000_0003;
      case (state_q)
        ST_IDLE: state_d = ST_REQ;
        // An accepted request can no longer be withdrawn, so its response must be dropped
        ST_REQ:  state_d = accept ? ST_DROP : ST_REQ;
        // A response landing in the redirect cycle is simply discarded
        ST_WAIT: state_d = imem_rvalid ? ST_REQ : ST_DROP;
        ST_DROP: state_d = imem_rvalid ? ST_REQ : ST_DROP;
        default: state_d = ST_REQ;
      endcase
    end
  end

  // FIFO pointer, occupancy and storage update; redirect clears the buffer
  always_comb begin
    pc_mem_d   = pc_mem_q;
    data_mem_d = data_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]   = fetch_pc_q;
        data_mem_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d             = wr_ptr_q + C_PTR1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + C_PTR1;
      end
      count_d = count_q + (push ? C_ONE : '0) - (pop ? C_ONE : '0);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      pc_mem_q   <= '{default: '0};
      data_mem_q <= '{default: '0};
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      pc_mem_q   <= pc_mem_d;
      data_mem_q <= data_mem_d;
    end
  end

  // Outputs are decoded from registered state only
  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? data_mem_q[rd_ptr_q] : C_NOP;
  assign instr_pc    = instr_valid ? pc_mem_q[rd_ptr_q]   : 32'h0000_0000;
  assign fifo_count  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_prefetch_unit
// Description : Directed self-checking bench for instr_prefetch_unit with a
//               behavioural instruction memory of configurable latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_prefetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  // memory model state
  int          lat = 1;
  int          acc_count = 0;
  logic [31:0] last_acc_addr = 32'h0;
  logic        m_acc;
  logic [31:0] m_ad;
  logic        m_pend = 1'b0;
  logic [31:0] m_pend_addr = 32'h0;
  int          m_cnt = 0;

  instr_prefetch_unit #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .CLK(CLK), .RESET(RESET),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .fifo_count(fifo_count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] fdata(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory: sample handshake just before the edge, respond lat cycles after acceptance
  always begin
    @(negedge CLK); #4;
    m_acc = imem_req && imem_ready;
    m_ad  = imem_addr;
    @(posedge CLK); #1;
    if (m_pend) begin
      if (m_cnt <= 1) m_pend = 1'b0;
      else m_cnt = m_cnt - 1;
    end
    if (m_acc) begin
      m_pend        = 1'b1;
      m_pend_addr   = m_ad;
      m_cnt         = lat;
      acc_count     = acc_count + 1;
      last_acc_addr = m_ad;
    end
    imem_rvalid = m_pend && (m_cnt == 1);
    imem_rdata  = imem_rvalid ? fdata(m_pend_addr) : 32'hDEAD_BEEF;
  end

  task automatic do_reset();
    RESET = 1'b1;
    redirect_valid = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_reset();
    stall = 1'b0; imem_ready = 1'b1; lat = 1;
    do_reset();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0h want 0", imem_req); end
    n_checks++; if (imem_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0h want 0", instr_valid); end
    n_checks++; if (instr !== NOP) begin n_fail++; $display("FAIL reset_instr: got %h want %h", instr, NOP); end
    n_checks++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", instr_pc); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    RESET = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    @(negedge CLK);
    n_checks++; if ({imem_req, imem_addr, instr_valid} !== {1'b1, RESET_PC, 1'b0}) begin
      n_fail++; $display("FAIL seq_first_req: got req=%0h addr=%h v=%0h want 1 %h 0", imem_req, imem_addr, instr_valid, RESET_PC); end
    @(negedge CLK);
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL seq_wait_valid: got %0h want 0", instr_valid); end
    for (int k = 0; k < 4; k++) begin
      exp_pc = RESET_PC + 32'(4 * k);
      @(negedge CLK);
      n_checks++; if ({instr_valid, instr_pc, instr, imem_req, imem_addr} !== {1'b1, exp_pc, fdata(exp_pc), 1'b1, exp_pc + 32'd4}) begin
        n_fail++; $display("FAIL seq_word%0d: got v=%0h pc=%h i=%h req=%0h a=%h want 1 %h %h 1 %h",
                           k, instr_valid, instr_pc, instr, imem_req, imem_addr, exp_pc, fdata(exp_pc), exp_pc + 32'd4); end
      @(negedge CLK);
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL seq_gap%0d: got %0h want 0", k, instr_valid); end
    end
  endtask

  task automatic test_stall_fill();
    int a0, a1;
    logic [31:0] exp_pc;
    stall = 1'b1; imem_ready = 1'b1; lat = 1;
    do_reset(); RESET = 1'b0;
    a0 = acc_count;
    repeat (20) @(negedge CLK);
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", fifo_count); end
    n_checks++; if ({imem_req, imem_addr} !== {1'b0, 32'h0000_3010}) begin
      n_fail++; $display("FAIL fill_req: got req=%0h addr=%h want 0 00003010", imem_req, imem_addr); end
    n_checks++; if (acc_count - a0 !== 4) begin n_fail++; $display("FAIL fill_accepts: got %0d want 4", acc_count - a0); end
    a1 = acc_count;
    repeat (3) @(negedge CLK);
    n_checks++; if (acc_count !== a1) begin n_fail++; $display("FAIL fill_no_accept: got %0d want %0d", acc_count, a1); end
    stall = 1'b0;
    for (int j = 0; j < 5; j++) begin
      exp_pc = RESET_PC + 32'(4 * j);
      n_checks++; if ({instr_valid, instr_pc, instr} !== {1'b1, exp_pc, fdata(exp_pc)}) begin
        n_fail++; $display("FAIL drain%0d: got v=%0h pc=%h i=%h want 1 %h %h", j, instr_valid, instr_pc, instr, exp_pc, fdata(exp_pc)); end
      if (j < 4) @(negedge CLK);
    end
    n_checks++; if ({acc_count - a1, last_acc_addr} !== {32'd1, 32'h0000_3010}) begin
      n_fail++; $display("FAIL drain_refetch: got n=%0d addr=%h want 1 00003010", acc_count - a1, last_acc_addr); end
  endtask

  task automatic test_redirect_wait();
    int t;
    stall = 1'b1; imem_ready = 1'b1; lat = 2;
    do_reset(); RESET = 1'b0;
    repeat (5) @(negedge CLK);
    n_checks++; if ({fifo_count, imem_req, last_acc_addr} !== {3'd1, 1'b0, 32'h0000_3004}) begin
      n_fail++; $display("FAIL redir_pre: got cnt=%0d req=%0h acc=%h want 1 0 00003004", fifo_count, imem_req, last_acc_addr); end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3102;
    @(negedge CLK);
    redirect_valid = 1'b0;
    n_checks++; if ({fifo_count, instr_valid, instr, imem_req} !== {3'd0, 1'b0, NOP, 1'b0}) begin
      n_fail++; $display("FAIL redir_flush: got cnt=%0d v=%0h i=%h req=%0h want 0 0 %h 0", fifo_count, instr_valid, instr, imem_req, NOP); end
    @(negedge CLK);
    n_checks++; if ({fifo_count, imem_req, imem_addr} !== {3'd0, 1'b1, 32'h0000_3100}) begin
      n_fail++; $display("FAIL redir_drop: got cnt=%0d req=%0h addr=%h want 0 1 00003100", fifo_count, imem_req, imem_addr); end
    t = 0;
    while (!instr_valid && t < 20) begin @(negedge CLK); t++; end
    n_checks++; if ({instr_valid, instr_pc, instr, fifo_count} !== {1'b1, 32'h0000_3100, fdata(32'h0000_3100), 3'd1}) begin
      n_fail++; $display("FAIL redir_target: got v=%0h pc=%h i=%h cnt=%0d want 1 00003100 %h 1", instr_valid, instr_pc, instr, fifo_count, fdata(32'h0000_3100)); end
  endtask

  task automatic test_ready_hold();
    int a0;
    stall = 1'b0; imem_ready = 1'b0; lat = 1;
    do_reset(); RESET = 1'b0;
    a0 = acc_count;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      n_checks++; if ({imem_req, imem_addr} !== {1'b1, RESET_PC}) begin
        n_fail++; $display("FAIL hold%0d: got req=%0h addr=%h want 1 %h", i, imem_req, imem_addr, RESET_PC); end
    end
    imem_ready = 1'b1;
    @(negedge CLK);
    n_checks++; if ({acc_count - a0, last_acc_addr, imem_req} !== {32'd1, RESET_PC, 1'b0}) begin
      n_fail++; $display("FAIL hold_accept: got n=%0d addr=%h req=%0h want 1 %h 0", acc_count - a0, last_acc_addr, imem_req, RESET_PC); end
  endtask

  task automatic test_wrap();
    int t;
    stall = 1'b0; imem_ready = 1'b0; lat = 1;
    do_reset(); RESET = 1'b0;
    @(negedge CLK);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    @(negedge CLK);
    redirect_valid = 1'b0;
    n_checks++; if ({imem_req, imem_addr, fifo_count} !== {1'b1, 32'hFFFF_FFFC, 3'd0}) begin
      n_fail++; $display("FAIL wrap_reissue: got req=%0h addr=%h cnt=%0d want 1 fffffffc 0", imem_req, imem_addr, fifo_count); end
    imem_ready = 1'b1;
    t = 0;
    while (!instr_valid && t < 20) begin @(negedge CLK); t++; end
    n_checks++; if ({instr_valid, instr_pc, instr} !== {1'b1, 32'hFFFF_FFFC, fdata(32'hFFFF_FFFC)}) begin
      n_fail++; $display("FAIL wrap_word: got v=%0h pc=%h i=%h want 1 fffffffc %h", instr_valid, instr_pc, instr, fdata(32'hFFFF_FFFC)); end
    n_checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL wrap_next: got req=%0h addr=%h want 1 00000000", imem_req, imem_addr); end
  endtask

  task automatic test_reset_midflight();
    int a0, t;
    stall = 1'b0; imem_ready = 1'b1; lat = 2;
    do_reset(); RESET = 1'b0;
    a0 = acc_count;
    repeat (2) @(negedge CLK);
    n_checks++; if ({imem_req, acc_count - a0} !== {1'b0, 32'd1}) begin
      n_fail++; $display("FAIL mid_wait: got req=%0h n=%0d want 0 1", imem_req, acc_count - a0); end
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    n_checks++; if ({fifo_count, imem_req, imem_addr} !== {3'd0, 1'b0, RESET_PC}) begin
      n_fail++; $display("FAIL mid_reset: got cnt=%0d req=%0h addr=%h want 0 0 %h", fifo_count, imem_req, imem_addr, RESET_PC); end
    @(negedge CLK);
    n_checks++; if ({fifo_count, instr_valid, imem_req, imem_addr} !== {3'd0, 1'b0, 1'b1, RESET_PC}) begin
      n_fail++; $display("FAIL mid_ignore: got cnt=%0d v=%0h req=%0h addr=%h want 0 0 1 %h", fifo_count, instr_valid, imem_req, imem_addr, RESET_PC); end
    t = 0;
    while (!instr_valid && t < 20) begin @(negedge CLK); t++; end
    n_checks++; if ({instr_valid, instr_pc, instr, fifo_count} !== {1'b1, RESET_PC, fdata(RESET_PC), 3'd1}) begin
      n_fail++; $display("FAIL mid_restart: got v=%0h pc=%h i=%h cnt=%0d want 1 %h %h 1", instr_valid, instr_pc, instr, fifo_count, RESET_PC, fdata(RESET_PC)); end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_sequential();
    test_stall_fill();
    test_redirect_wait();
    test_ready_hold();
    test_wrap();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
